// File: rtl/logicunit_checker.sv
// logicunit_checker: checks a 2-input logic unit sample by sample, tracking coverage,
// error count and the first failing sample of each run.
module logicunit_checker #(
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        sample_valid,
    input  logic        A,
    input  logic        B,
    input  logic [1:0]  control,
    input  logic        out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  error_count,
    output logic [15:0] covered,
    output logic [4:0]  first_fail,
    output logic        first_fail_valid
);
    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;
    state_t state;
    logic        expected;
    logic        mismatch;
    logic [3:0]  idx;
    logic [15:0] cov_next;
    logic [7:0]  err_next;
    always_comb begin
        expected = control == 2'd0 ? (A & B) :
                   control == 2'd1 ? (A | B) :
                   control == 2'd2 ? ~(A | B) : (A ^ B);
        mismatch = out != expected;
        idx      = {control, A, B};
        cov_next = covered | (16'd1 << idx);
        err_next = (mismatch && error_count != 8'hFF) ? error_count + 8'd1 : error_count;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            error_count      <= 8'd0;
            covered          <= 16'd0;
            first_fail       <= 5'd0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state            <= CHECK;
                    busy             <= 1'b1;
                    done             <= 1'b0;
                    pass             <= 1'b0;
                    error_count      <= 8'd0;
                    covered          <= 16'd0;
                    first_fail       <= 5'd0;
                    first_fail_valid <= 1'b0;
                end
                CHECK: if (sample_valid) begin
                    covered     <= cov_next;
                    error_count <= err_next;
                    if (mismatch && !first_fail_valid) begin
                        first_fail       <= {control, A, B, out};
                        first_fail_valid <= 1'b1;
                    end
                    // Full coverage or an early stop both finish the run with this sample included
                    if (cov_next == 16'hFFFF || (STOP_ON_FAIL && mismatch)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= cov_next == 16'hFFFF && err_next == 8'd0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_logicunit_checker.sv
// tb_logicunit_checker: directed checks of logicunit_checker, one instance per STOP_ON_FAIL setting.
module tb_logicunit_checker;
    logic        clock = 1'b0;
    logic        reset = 1'b0, start = 1'b0, sample_valid = 1'b0, A = 1'b0, B = 1'b0, out = 1'b0;
    logic [1:0]  control = 2'd0;
    logic        busy, done, pass, first_fail_valid;
    logic [7:0]  error_count;
    logic [15:0] covered;
    logic [4:0]  first_fail;
    logic        s_busy, s_done, s_pass, s_first_fail_valid;
    logic [7:0]  s_error_count;
    logic [15:0] s_covered;
    logic [4:0]  s_first_fail;
    int n = 0;
    int fails = 0;

    always #5 clock = ~clock;

    logicunit_checker #(.STOP_ON_FAIL(1'b0)) dut (
        .clock(clock), .reset(reset), .start(start), .sample_valid(sample_valid),
        .A(A), .B(B), .control(control), .out(out),
        .busy(busy), .done(done), .pass(pass), .error_count(error_count),
        .covered(covered), .first_fail(first_fail), .first_fail_valid(first_fail_valid)
    );

    logicunit_checker #(.STOP_ON_FAIL(1'b1)) dut_s (
        .clock(clock), .reset(reset), .start(start), .sample_valid(sample_valid),
        .A(A), .B(B), .control(control), .out(out),
        .busy(s_busy), .done(s_done), .pass(s_pass), .error_count(s_error_count),
        .covered(s_covered), .first_fail(s_first_fail), .first_fail_valid(s_first_fail_valid)
    );

    function automatic logic ref_out(input logic [1:0] c, input logic a, input logic b);
        case (c)
            2'd0: return a & b;
            2'd1: return a | b;
            2'd2: return ~(a | b);
            default: return a ^ b;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic rs, input logic st, input logic sv,
                        input logic [3:0] i, input logic o);
        reset = rs; start = st; sample_valid = sv;
        control = i[3:2]; A = i[1]; B = i[0]; out = o;
        @(posedge clock);
        #1;
        reset = 1'b0; start = 1'b0; sample_valid = 1'b0;
    endtask

    task automatic sweep(input int flip);
        for (int i = 0; i < 16; i++) begin
            logic [3:0] k;
            k = 4'(i);
            tick(1'b0, 1'b0, 1'b1, k, ref_out(k[3:2], k[1], k[0]) ^ (i == flip));
            if (i == 14 && flip < 0) begin
                chk("sweep_cov15", covered, 16'h7FFF);
                chk("sweep_busy15", busy, 1'b1);
            end
        end
    endtask

    initial begin
        tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_err", error_count, 8'd0);
        chk("rst_cov", covered, 16'd0);
        chk("rst_ff", first_fail, 5'd0);
        chk("rst_ffv", first_fail_valid, 1'b0);

        tick(1'b0, 1'b0, 1'b1, 4'd5, 1'b0);
        chk("idle_sample_cov", covered, 16'd0);
        chk("idle_sample_busy", busy, 1'b0);

        tick(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("start_busy", busy, 1'b1);
        chk("start_done", done, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("start_in_check_busy", busy, 1'b1);
        chk("start_in_check_cov", covered, 16'd0);

        sweep(-1);
        chk("clean_done", done, 1'b1);
        chk("clean_busy", busy, 1'b0);
        chk("clean_pass", pass, 1'b1);
        chk("clean_err", error_count, 8'd0);
        chk("clean_cov", covered, 16'hFFFF);
        chk("clean_ffv", first_fail_valid, 1'b0);

        tick(1'b0, 1'b0, 1'b1, 4'd0, 1'b1);
        chk("done_hold_err", error_count, 8'd0);
        chk("done_hold_pass", pass, 1'b1);
        chk("done_hold_done", done, 1'b1);

        tick(1'b0, 1'b1, 1'b1, 4'd0, 1'b1);
        chk("restart_busy", busy, 1'b1);
        chk("restart_cov", covered, 16'd0);
        chk("restart_err", error_count, 8'd0);
        chk("restart_pass", pass, 1'b0);

        sweep(10);
        chk("fail_done", done, 1'b1);
        chk("fail_pass", pass, 1'b0);
        chk("fail_err", error_count, 8'd1);
        chk("fail_ffv", first_fail_valid, 1'b1);
        chk("fail_ff", first_fail, 5'b10101);
        chk("stop_sweep_done", s_done, 1'b1);
        chk("stop_sweep_cov", s_covered, 16'h07FF);
        chk("stop_sweep_err", s_error_count, 8'd1);

        tick(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        sweep(-1);
        chk("rerun_pass", pass, 1'b1);
        chk("rerun_err", error_count, 8'd0);
        chk("rerun_ffv", first_fail_valid, 1'b0);

        tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        tick(1'b0, 1'b0, 1'b1, 4'd15, 1'b1);
        chk("stop_done", s_done, 1'b1);
        chk("stop_busy", s_busy, 1'b0);
        chk("stop_err", s_error_count, 8'd1);
        chk("stop_cov", s_covered, 16'h8000);
        chk("stop_pass", s_pass, 1'b0);
        chk("stop_ff", s_first_fail, 5'b11111);
        chk("nostop_busy", busy, 1'b1);
        chk("nostop_err", error_count, 8'd1);

        tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            tick(1'b0, 1'b0, 1'b1, 4'd0, 1'b1);
            if (i == 253) chk("sat_err_254", error_count, 8'd254);
        end
        chk("sat_err", error_count, 8'd255);
        chk("sat_cov", covered, 16'h0001);
        chk("sat_busy", busy, 1'b1);
        chk("sat_ff", first_fail, 5'b00001);

        tick(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            logic [3:0] k;
            k = 4'(i);
            tick(1'b0, 1'b0, 1'b1, k, ref_out(k[3:2], k[1], k[0]));
        end
        chk("mid_cov", covered, 16'h001F);
        tick(1'b1, 1'b1, 1'b1, 4'd6, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_cov", covered, 16'd0);
        chk("mid_rst_err", error_count, 8'd0);
        tick(1'b0, 1'b0, 1'b1, 4'd6, 1'b1);
        chk("post_rst_cov", covered, 16'd0);
        chk("post_rst_ffv", first_fail_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
        $finish;
    end
endmodule
